// File: rtl/siso_sched_pkg.sv
// Shared types and defaults for the round-robin serial channel scheduler.
// Holds the FSM state type and the default requester count and word width.
package siso_sched_pkg;

   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StShift = 1'b1
   } sched_state_e;

   localparam int unsigned DefNreq  = 4;
   localparam int unsigned DefWidth = 8;

endpackage

// File: rtl/siso_channel_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The pointer itself lives in the caller.
module rr_arbiter
   import siso_sched_pkg::*;
#(
   parameter  int unsigned NREQ = DefNreq,
   localparam int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx
);

   logic            found;
   int unsigned     sum;
   logic [IDW-1:0]  cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      sum   = 0;
      cand  = '0;
      // Walk candidates ptr, ptr+1, ... modulo NREQ; first hit wins.
      for (int unsigned i = 0; i < NREQ; i++) begin
         sum = 32'(ptr) + i;
         if (sum >= NREQ) begin
            sum = sum - NREQ;
         end
         cand = IDW'(sum);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/siso_channel_sched.sv
// Shares one LSB-first serial channel between NREQ word requesters, granting
// round-robin and framing each word with valid, source id and done.
module siso_channel_sched
   import siso_sched_pkg::*;
#(
   parameter  int unsigned NREQ  = DefNreq,
   parameter  int unsigned WIDTH = DefWidth,
   localparam int unsigned IDW   = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         gnt,
   output logic                    sout,
   output logic                    sout_valid,
   output logic [IDW-1:0]          sout_id,
   output logic                    done,
   output logic                    busy
);

   localparam int unsigned    CntW    = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
   localparam logic [IDW-1:0]  LastId  = IDW'(NREQ - 1);

   sched_state_e    state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CntW-1:0] bitcnt_q, bitcnt_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            done_q, done_d;

   logic [NREQ-1:0] arb_gnt;
   logic [IDW-1:0]  arb_idx;
   logic [WIDTH-1:0] win_word;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr_arbiter (
      .req  (req),
      .ptr  (ptr_q),
      .gnt  (arb_gnt),
      .idx  (arb_idx)
   );

   // One-hot AND-OR mux of the winning requester's word.
   always_comb begin
      win_word = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         win_word = win_word | (req_data[i*WIDTH +: WIDTH] & {WIDTH{arb_gnt[i]}});
      end
   end

   always_comb begin
      state_d  = state_q;
      sreg_d   = sreg_q;
      bitcnt_d = bitcnt_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      gnt_d    = '0;
      done_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (|req) begin
               state_d  = StShift;
               sreg_d   = win_word;
               id_d     = arb_idx;
               gnt_d    = arb_gnt;
               bitcnt_d = '0;
            end
         end
         StShift: begin
            sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            if (bitcnt_q == LastBit) begin
               state_d  = StIdle;
               bitcnt_d = '0;
               // sreg is fully drained here, so sout stays 0 while idle.
               sreg_d   = '0;
               ptr_d    = (id_q == LastId) ? '0 : id_q + 1'b1;
               id_d     = '0;
            end else begin
               bitcnt_d = bitcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // done is registered, so it is raised on entry to the last bit cycle.
      done_d = (state_d == StShift) && (bitcnt_d == LastBit);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         sreg_q   <= '0;
         bitcnt_q <= '0;
         ptr_q    <= '0;
         id_q     <= '0;
         gnt_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sreg_q   <= sreg_d;
         bitcnt_q <= bitcnt_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
      end
   end

   assign gnt        = gnt_q;
   assign sout       = sreg_q[0];
   assign sout_valid = (state_q == StShift);
   assign busy       = (state_q == StShift);
   assign sout_id    = id_q;
   assign done       = done_q;

endmodule

// File: tb/tb_siso_channel_sched.sv
// Self-checking bench for siso_channel_sched: directed scenarios plus random
// requesters, all compared against a frame-queue reference model.
module tb_siso_channel_sched;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;
   localparam int VW    = NREQ + IDW + 4;

   logic                  clk;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       gnt;
   logic                  sout;
   logic                  sout_valid;
   logic [IDW-1:0]        sout_id;
   logic                  done;
   logic                  busy;

   siso_channel_sched #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_data   (req_data),
      .gnt        (gnt),
      .sout       (sout),
      .sout_valid (sout_valid),
      .sout_id    (sout_id),
      .done       (done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one entry per expected output cycle.
   typedef struct {
      logic [NREQ-1:0] gnt;
      logic            sout;
      logic            valid;
      int              id;
      logic            done;
   } cyc_t;

   cyc_t cur;
   cyc_t fq[$];
   int   mptr;
   int   nvec;
   int   nmis;

   logic [VW-1:0] obs;
   assign obs = {gnt, sout, sout_valid, sout_id, done, busy};

   function automatic cyc_t idle_cyc();
      cyc_t c;
      c.gnt = '0; c.sout = 1'b0; c.valid = 1'b0; c.id = 0; c.done = 1'b0;
      return c;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      return {cur.gnt, cur.sout, cur.valid, IDW'(cur.id), cur.done, cur.valid};
   endfunction

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NREQ; i++) if (v[IDW'(i)]) r = i;
      return r;
   endfunction

   // Advance the model across one rising edge using the inputs seen there.
   task automatic model_step();
      int w;
      int c;
      logic [WIDTH-1:0] word;
      cyc_t e;
      if (!reset) begin
         fq.delete();
         cur  = idle_cyc();
         mptr = 0;
      end else if (cur.valid) begin
         if (fq.size() > 0) begin
            cur = fq.pop_front();
         end else begin
            mptr = (cur.id + 1) % NREQ;
            cur  = idle_cyc();
         end
      end else if (req != '0) begin
         w = -1;
         for (int k = 0; k < NREQ; k++) begin
            c = (mptr + k) % NREQ;
            if (w < 0 && req[IDW'(c)]) w = c;
         end
         word = WIDTH'(req_data >> (w * WIDTH));
         for (int b = 0; b < WIDTH; b++) begin
            e.gnt   = (b == 0) ? (NREQ'(1) << w) : '0;
            e.sout  = word[b];
            e.valid = 1'b1;
            e.id    = w;
            e.done  = (b == WIDTH - 1);
            fq.push_back(e);
         end
         cur = fq.pop_front();
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_word(input int i, input logic [WIDTH-1:0] w);
      logic [NREQ*WIDTH-1:0] m;
      logic [NREQ*WIDTH-1:0] v;
      m = {{(NREQ-1)*WIDTH{1'b0}}, {WIDTH{1'b1}}} << (i * WIDTH);
      v = {{(NREQ-1)*WIDTH{1'b0}}, w} << (i * WIDTH);
      req_data = (req_data & ~m) | v;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req   = '0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req   = '1;
      for (int c = 0; c < 3; c++) begin
         tick();
         nvec++;
         if (obs !== '0) begin
            nmis++;
            $display("FAIL reset_outputs cyc=%0d got=%b want=%b", c, obs, {VW{1'b0}});
         end
      end
      req   = '0;
      reset = 1'b1;
   endtask

   task automatic test_single();
      logic [WIDTH-1:0] got;
      do_reset();
      set_word(0, 8'hA5);
      req = 4'b0001;
      got = '0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         tick();
         nvec++;
         if (obs !== exp_vec()) begin
            nmis++;
            $display("FAIL single_model cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
         end
         if (cyc >= 1 && cyc <= WIDTH) got[cyc-1] = sout;
         nvec++;
         if (done !== (cyc == WIDTH)) begin
            nmis++;
            $display("FAIL single_done cyc=%0d got=%b want=%b", cyc, done, cyc == WIDTH);
         end
         if (cyc == 1) begin
            nvec++;
            if (gnt !== 4'b0001 || sout_id !== 2'd0) begin
               nmis++;
               $display("FAIL single_gnt got=%b/%0d want=0001/0", gnt, sout_id);
            end
            req = '0;
         end
         if (cyc == 9) begin
            nvec++;
            if (busy !== 1'b0) begin
               nmis++;
               $display("FAIL single_busy_end got=%b want=0", busy);
            end
         end
      end
      nvec++;
      if (got !== 8'hA5) begin
         nmis++;
         $display("FAIL single_bits got=%h want=a5", got);
      end
   endtask

   task automatic test_all_rr();
      int order[$];
      int g;
      do_reset();
      set_word(0, 8'h01); set_word(1, 8'h02); set_word(2, 8'h04); set_word(3, 8'h08);
      req = 4'b1111;
      for (int cyc = 1; cyc <= 45; cyc++) begin
         tick();
         nvec++;
         if (obs !== exp_vec()) begin
            nmis++;
            $display("FAIL all_rr_model cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
         end
         g = onehot_idx(gnt);
         if (gnt != '0) order.push_back(g);
      end
      req = '0;
      nvec++;
      if (order.size() != 5) begin
         nmis++;
         $display("FAIL all_rr_count got=%0d want=5", order.size());
      end
      for (int k = 0; k < order.size() && k < 5; k++) begin
         nvec++;
         if (order[k] != k % NREQ) begin
            nmis++;
            $display("FAIL all_rr_order k=%0d got=%0d want=%0d", k, order[k], k % NREQ);
         end
      end
   endtask

   task automatic test_wrap();
      int order[$];
      int want[3];
      want[0] = 3; want[1] = 0; want[2] = 3;
      do_reset();
      set_word(3, 8'($urandom));
      set_word(0, 8'($urandom));
      req = 4'b1000;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         tick();
         nvec++;
         if (obs !== exp_vec()) begin
            nmis++;
            $display("FAIL wrap_model cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
         end
         if (gnt != '0) begin
            order.push_back(onehot_idx(gnt));
            req = 4'b1001;
         end
      end
      req = '0;
      for (int k = 0; k < 3; k++) begin
         nvec++;
         if (k >= order.size() || order[k] != want[k]) begin
            nmis++;
            $display("FAIL wrap_order k=%0d got=%0d want=%0d", k,
                     (k < order.size()) ? order[k] : -1, want[k]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int dcnt;
      dcnt = 0;
      do_reset();
      set_word(0, 8'hFF);
      req = 4'b0001;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         tick();
         nvec++;
         if (obs !== exp_vec()) begin
            nmis++;
            $display("FAIL rstmid_model cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
         end
         if (cyc <= 6 && done) dcnt++;
         if (cyc == 5) reset = 1'b0;
         if (cyc == 6) begin
            nvec++;
            if (obs !== '0) begin
               nmis++;
               $display("FAIL rstmid_zero got=%b want=%b", obs, {VW{1'b0}});
            end
            reset = 1'b1;
         end
         if (cyc == 7) begin
            nvec++;
            if (gnt !== 4'b0001 || sout_valid !== 1'b1) begin
               nmis++;
               $display("FAIL rstmid_restart got=%b/%b want=0001/1", gnt, sout_valid);
            end
            req = '0;
         end
      end
      nvec++;
      if (dcnt != 0) begin
         nmis++;
         $display("FAIL rstmid_done got=%0d want=0", dcnt);
      end
   endtask

   task automatic test_req_change();
      logic [WIDTH-1:0] w0;
      logic [WIDTH-1:0] got;
      do_reset();
      w0 = 8'($urandom);
      set_word(0, w0);
      set_word(1, 8'($urandom));
      req = 4'b0001;
      got = '0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         tick();
         nvec++;
         if (obs !== exp_vec()) begin
            nmis++;
            $display("FAIL reqchg_model cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
         end
         if (cyc <= WIDTH) got[cyc-1] = sout;
         if (cyc == 1) req = '0;
         if (cyc == 4) begin
            req = 4'b0010;
            set_word(0, ~w0);
         end
         if (cyc == 10) begin
            nvec++;
            if (gnt !== 4'b0010 || sout_id !== 2'd1) begin
               nmis++;
               $display("FAIL reqchg_next got=%b/%0d want=0010/1", gnt, sout_id);
            end
            req = '0;
         end
      end
      nvec++;
      if (got !== w0) begin
         nmis++;
         $display("FAIL reqchg_bits got=%h want=%h", got, w0);
      end
   endtask

   task automatic test_idle();
      do_reset();
      req = '0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         tick();
         nvec++;
         if (obs !== '0 || obs !== exp_vec()) begin
            nmis++;
            $display("FAIL idle cyc=%0d got=%b want=%b", cyc, obs, {VW{1'b0}});
         end
      end
   endtask

   task automatic test_random();
      logic [IDW-1:0] ii;
      do_reset();
      for (int cyc = 1; cyc <= 600; cyc++) begin
         tick();
         nvec++;
         if (obs !== exp_vec()) begin
            nmis++;
            $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs, exp_vec());
         end
         if (!reset) reset = 1'b1;
         else if ($urandom_range(149) == 0) reset = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            ii = IDW'(i);
            if (req[ii]) begin
               if (cur.gnt[ii] ? ($urandom_range(1) == 0) : ($urandom_range(19) == 0))
                  req[ii] = 1'b0;
            end else if ($urandom_range(2) == 0) begin
               set_word(i, 8'($urandom));
               req[ii] = 1'b1;
            end
         end
      end
      req = '0;
   endtask

   initial begin
      nvec     = 0;
      nmis     = 0;
      mptr     = 0;
      cur      = idle_cyc();
      reset    = 1'b0;
      req      = '0;
      req_data = '0;
      test_reset();
      test_single();
      test_all_rr();
      test_wrap();
      test_reset_mid();
      test_req_change();
      test_idle();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/siso_channel_sched.md
# siso_channel_sched

Round-robin scheduler that shares one serial shift-out channel between NREQ parallel-word requesters. Grants one requester at a time, captures its word into an internal right-shifting register and emits it LSB-first, one bit per clock, with frame-valid, source-id and done indications. Sits in front of the serial shift-register datapath and sequences every load/shift/idle on it.

## Interface
- NREQ, 4, number of requesters (≥2)
- WIDTH, 8, bits per word / frame length (≥2)
- IDW, $clog2(NREQ), width of source id (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low
- req  in  NREQ  per-requester request level, held until own gnt seen
- req_data  in  NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH], stable while req[i]=1
- gnt  out  NREQ  one-hot, one-cycle grant pulse on first shift cycle
- sout  out  1  serial data, LSB first; 0 when sout_valid=0
- sout_valid  out  1  high during every bit cycle of a frame
- sout_id  out  IDW  index of requester owning current frame; 0 when idle
- done  out  1  one-cycle pulse coincident with last bit
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, SHIFT.
- IDLE: if any req bit set, rr_arbiter picks winner w = first set bit at or after pointer ptr (wrapping); at the edge: sreg ← req_data[w], sout_id ← w, gnt ← onehot(w), bitcnt ← 0, state ← SHIFT. No req: stay, outputs 0.
- SHIFT: sout = sreg[0]; each edge sreg ← {1'b0, sreg[WIDTH-1:1]}, bitcnt++; gnt returns to 0 after first SHIFT cycle.
- When bitcnt = WIDTH-1: done=1 this cycle; at edge state ← IDLE, ptr ← (sout_id+1) mod NREQ, sout_id ← 0.
- req sampled only in IDLE; req changes during SHIFT ignored. Requester may drop req any time after gnt.
- Requester dropping req before grant simply loses arbitration; no error.
- ptr reset value 0 → requester 0 has highest priority after reset.
- All outputs registered.

## Timing
- Reset (reset=0 at an edge): state IDLE, ptr 0, sreg 0, bitcnt 0; gnt=0, sout=0, sout_valid=0, sout_id=0, done=0, busy=0 from next cycle. Reset mid-frame abandons the frame: no done, no ptr advance.
- Request seen in IDLE cycle 0 → gnt, sout_valid, busy high in cycle 1; bit k of word on sout in cycle 1+k; done in cycle WIDTH; cycle WIDTH+1 is IDLE (arbitration cycle).
- Back-to-back frames: one idle cycle between frames; throughput WIDTH bits per WIDTH+1 cycles.
- Simultaneous requests: strict round-robin; with all NREQ requesting continuously, grants cycle 0,1,…,NREQ-1,0.
- Wrap: ptr at NREQ-1 wraps to 0; winner search wraps past NREQ-1.
- bitcnt width $clog2(WIDTH); no overflow since it clears on entry to SHIFT.

## Structure
- Shared package siso_sched_pkg: state enum typedef (IDLE, SHIFT), default NREQ/WIDTH localparams.
- Sub-module rr_arbiter (NREQ param): inputs req, ptr; output one-hot grant and encoded index; purely combinational, pointer register stays in top.
- Top holds FSM, sreg, bitcnt, ptr, output registers.

## Test plan
- Single request: req=4'b0001, word0=8'hA5 → gnt=4'b0001 in cycle 1; sout 1,0,1,0,0,1,0,1 in cycles 1–8; sout_id=0; done in cycle 8 only; busy low in cycle 9.
- All request together, words 8'h01,8'h02,8'h04,8'h08 held → grant order 0,1,2,3,0; each frame 8 valid cycles separated by exactly one idle cycle; sout_id matches.
- Pointer wrap: after a frame for requester 3, req=4'b1001 → requester 0 wins; after frame 0, same req → requester 3 wins.
- Reset mid-frame: reset low at bit 4 of word 8'hFF → next cycle all outputs 0, no done; after reset release with req0 still high, full frame restarts with requester 0.
- Req change during SHIFT: req1 rises at bit 3 of frame 0 and word0 altered → frame 0 bits unchanged; requester 1 granted in cycle after the idle cycle.
- Idle stability: req=0 for 20 cycles → sout, sout_valid, gnt, done, busy constant 0.
